// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and arbiter state encoding for the memory port arbiter
package mips_pkg;

  localparam int MIPS_ADDR_W     = 32;
  localparam int MIPS_DATA_W     = 32;
  localparam int ARB_TIMEOUT_CYC = 16;

  localparam int ARB_ST_W = 2;
  localparam logic [ARB_ST_W-1:0] ARB_IDLE   = 2'd0;
  localparam logic [ARB_ST_W-1:0] ARB_BUSY_D = 2'd1;
  localparam logic [ARB_ST_W-1:0] ARB_BUSY_I = 2'd2;
  localparam logic [ARB_ST_W-1:0] ARB_DONE   = 2'd3;

  function automatic logic arb_is_busy(input logic [ARB_ST_W-1:0] st);
    return (st == ARB_BUSY_D) || (st == ARB_BUSY_I);
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// rtl/arb_timeout_ctr.sv - wait-cycle counter that flags an expired memory transaction
module arb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int  CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int  LAST_INT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] LAST = LAST_INT[CNT_W-1:0];
  localparam bit  ENABLED  = (TIMEOUT_CYC != 0);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at LAST so a disabled or unqualified count can never wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = ENABLED && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between the IF and MEM pipeline stages
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W      = MIPS_ADDR_W,
  parameter int DATA_W      = MIPS_DATA_W,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              pipe_stall,
  output logic              bus_err
);

  logic [ARB_ST_W-1:0] r_state;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_ack;
  logic                r_d_ack;
  logic                r_bus_err;

  logic                w_idle;
  logic                w_busy;
  logic                w_grant;
  logic                w_expired;
  logic                w_finish;
  logic [DATA_W-1:0]   w_rdata_cap;

  assign w_idle  = (r_state == ARB_IDLE);
  assign w_busy  = arb_is_busy(r_state);
  assign w_grant = w_idle && (d_req || if_req);

  arb_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .i_clk    (Clk),
    .i_rst    (Rst),
    .i_clr    (w_grant),
    .i_en     (w_busy && !mem_ready),
    .o_expired(w_expired)
  );

  // A ready arriving on the abort cycle still completes the access normally.
  assign w_finish    = w_busy && (mem_ready || w_expired);
  assign w_rdata_cap = mem_ready ? mem_rdata : '0;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= ARB_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          // Data side wins: its instruction is older in the pipeline.
          if (d_req) begin
            r_state     <= ARB_BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_we ? d_wdata : '0;
          end else if (if_req) begin
            r_state     <= ARB_BUSY_I;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
          end
        end
        ARB_BUSY_D, ARB_BUSY_I: begin
          if (w_finish) begin
            r_state     <= ARB_DONE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_bus_err   <= !mem_ready;
            if (r_state == ARB_BUSY_D) begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= w_rdata_cap;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_rdata_cap;
            end
          end
        end
        default: begin
          r_state   <= ARB_IDLE;
          r_if_ack  <= 1'b0;
          r_d_ack   <= 1'b0;
          r_bus_err <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign if_rdata   = r_if_rdata;
  assign d_rdata    = r_d_rdata;
  assign if_ack     = r_if_ack;
  assign d_ack      = r_d_ack;
  assign bus_err    = r_bus_err;
  assign pipe_stall = (if_req && !r_if_ack) || (d_req && !r_d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural memory
module tb_mem_port_arbiter;

  localparam int TMO = 16;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        pipe_stall;
  logic        bus_err;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .Clk(Clk), .Rst(Rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pipe_stall(pipe_stall), .bus_err(bus_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          port_i;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          req_int;
    int          w;
  } exp_t;

  exp_t exp_q[$];
  int   wait_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] mem_arr   [logic [31:0]];

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] arr_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected at cycle %0d", name, cyc);
  endtask

  // Memory: ready after w wait cycles, returns old contents, commits stores on ready.
  int rsp_k = 0;
  int rsp_w = 0;
  bit rsp_active = 0;
  always @(posedge Clk) begin
    #1;
    if (Rst || !mem_req) begin
      rsp_active = 0;
    end else if (!rsp_active) begin
      rsp_active = 1;
      rsp_k = 0;
      rsp_w = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
    end else begin
      rsp_k++;
    end
    if (rsp_active && rsp_k == rsp_w) begin
      mem_ready = 1'b1;
      mem_rdata = arr_rd(mem_addr);
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
  end

  // Monitor: grants and acks are compared against the scoreboard queue.
  exp_t cur;
  bit   prev_mem_req = 0;
  bit   active = 0;
  bit   stable = 1;
  int   rise_cyc = 0;
  int   last_ack = -100;
  always @(negedge Clk) begin
    if (Rst) begin
      active = 0;
      last_ack = -100;
    end else begin
      check("pipe_stall", pipe_stall, (if_req && !if_ack) || (d_req && !d_ack));
      if (mem_req && !prev_mem_req) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_grant");
        end else begin
          int er;
          cur = exp_q[0];
          er = cur.req_int + 1;
          if (last_ack + 2 > er) er = last_ack + 2;
          check("grant_cycle", cyc, er);
          check("mem_addr", mem_addr, cur.addr);
          check("mem_we", mem_we, cur.we);
          check("mem_wdata", mem_wdata, cur.wdata);
          active = 1;
          stable = 1;
          rise_cyc = cyc;
        end
      end else if (mem_req && active) begin
        if (mem_addr !== cur.addr || mem_we !== cur.we || mem_wdata !== cur.wdata) stable = 0;
      end
      if (if_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_ack");
        end else begin
          int wl;
          cur = exp_q.pop_front();
          wl = (cur.w > TMO - 1) ? TMO - 1 : cur.w;
          check("ack_port", {if_ack, d_ack}, cur.port_i ? 2'b10 : 2'b01);
          check(cur.port_i ? "if_rdata" : "d_rdata", cur.port_i ? if_rdata : d_rdata, cur.rdata);
          check("bus_err", bus_err, cur.err);
          check("ack_cycle", cyc, rise_cyc + wl + 1);
          check("mem_req_in_ack", mem_req, 1'b0);
          check("mem_stable", stable, 1'b1);
          last_ack = cyc;
          active = 0;
        end
      end else if (bus_err) begin
        flag("stray_bus_err");
      end
    end
    prev_mem_req = mem_req;
  end

  function automatic int pick_wait();
    int v = $urandom_range(0, 19);
    if (v < 12) return v % 4;
    if (v < 15) return 14 + (v - 12);
    return 20 + v;
  endfunction

  task automatic run_round(input bit has_i, input bit has_d, input bit we,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw,
                           input int wi, input int wd, input bit drop_d);
    exp_t e;
    int   t0;
    bit   pend_i, pend_d, seen_i, seen_d;
    @(posedge Clk); #1;
    if (has_d) begin
      e.port_i = 0; e.addr = da; e.we = we; e.wdata = we ? dw : 32'h0;
      e.req_int = cyc; e.w = wd;
      if (wd <= TMO - 1) begin
        e.rdata = model_rd(da); e.err = 0;
        if (we) model_mem[da] = dw;
      end else begin
        e.rdata = 32'h0; e.err = 1;
      end
      exp_q.push_back(e);
      wait_q.push_back(wd);
      d_req = 1; d_we = we; d_addr = da; d_wdata = dw;
    end
    if (has_i) begin
      e.port_i = 1; e.addr = ia; e.we = 0; e.wdata = 32'h0;
      e.req_int = cyc; e.w = wi;
      if (wi <= TMO - 1) begin
        e.rdata = model_rd(ia); e.err = 0;
      end else begin
        e.rdata = 32'h0; e.err = 1;
      end
      exp_q.push_back(e);
      wait_q.push_back(wi);
      if_req = 1; if_addr = ia;
    end
    pend_d = has_d; pend_i = has_i; t0 = cyc;
    while ((pend_d || pend_i) && cyc < t0 + 200) begin
      @(negedge Clk);
      seen_d = d_ack; seen_i = if_ack;
      @(posedge Clk); #1;
      if (seen_d && pend_d) begin d_req = 0; pend_d = 0; end
      if (seen_i && pend_i) begin if_req = 0; pend_i = 0; end
      if (drop_d && cyc == t0 + 2) begin
        d_req = 0; d_we = $urandom; d_addr = $urandom; d_wdata = $urandom;
      end
    end
    if (pend_d || pend_i) begin
      flag("round_timeout");
      d_req = 0; if_req = 0;
      exp_q.delete(); wait_q.delete();
    end
  endtask

  initial begin
    mem_arr[32'h0040_0000]   = 32'h2008_0005;
    model_mem[32'h0040_0000] = 32'h2008_0005;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_acks", {if_ack, d_ack, bus_err}, 3'b000);
    check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    Rst = 0;

    run_round(1, 0, 0, 32'h0040_0000, 32'h0, 32'h0, 0, 0, 0);
    run_round(1, 1, 0, 32'h0040_0004, 32'h1000_0004, 32'h0, 0, 0, 0);
    run_round(0, 1, 1, 32'h0, 32'h1000_0008, 32'hDEAD_BEEF, 0, 3, 0);
    run_round(1, 0, 0, 32'h0040_0008, 32'h0, 32'h0, 40, 0, 0);
    run_round(0, 1, 0, 32'h0, 32'h1000_0008, 32'h0, 0, 1, 0);
    run_round(1, 1, 0, 32'h0040_000C, 32'h1000_000C, 32'h0, 1, 2, 1);

    for (int r = 0; r < 60; r++) begin
      int  sel = $urandom_range(0, 2);
      bit  hi = (sel != 1);
      bit  hd = (sel != 0);
      logic [31:0] ia = 32'h0040_0000 + {$urandom_range(0, 31), 2'b00};
      logic [31:0] da = 32'h1000_0000 + {$urandom_range(0, 15), 2'b00};
      run_round(hi, hd, $urandom_range(0, 1), ia, da, $urandom, pick_wait(), pick_wait(),
                hd && ($urandom_range(0, 3) == 0));
    end

    begin
      exp_t e;
      @(posedge Clk); #1;
      e.port_i = 0; e.addr = 32'h1000_0010; e.we = 1; e.wdata = 32'hCAFE_F00D;
      e.rdata = 32'h0; e.err = 0; e.req_int = cyc; e.w = 30;
      exp_q.push_back(e);
      wait_q.push_back(30);
      d_req = 1; d_we = 1; d_addr = 32'h1000_0010; d_wdata = 32'hCAFE_F00D;
      repeat (3) @(posedge Clk);
      #3;
      check("busy_before_reset", mem_req, 1'b1);
      Rst = 1;
      #1;
      check("reset_abort", {mem_req, d_ack, bus_err}, 3'b000);
      exp_q.delete(); wait_q.delete();
      @(posedge Clk); #1;
      d_req = 0;
      @(posedge Clk); #1;
      Rst = 0;
    end

    run_round(0, 1, 0, 32'h0, 32'h1000_0010, 32'h0, 0, 0, 0);
    run_round(1, 1, 0, 32'h0040_0010, 32'h1000_0014, 32'h0, 2, 15, 0);
    run_round(1, 0, 0, 32'h0040_0000, 32'h0, 32'h0, 16, 0, 0);

    repeat (4) @(posedge Clk);
    #1;
    if (exp_q.size() != 0) flag("leftover_expected");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
